// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle one-bit-per-cycle shifter sequencer (SLL/SRL/SRA)
//
// Ports:
//   clk_i    in   1   clock, rising edge
//   rst_i    in   1   synchronous active-low reset
//   start_i  in   1   request to start a shift operation
//   flush_i  in   1   abandon any operation in progress
//   op_i     in   6   instruction opcode field (must be 0 for a shift)
//   funct_i  in   6   instruction funct field (0 SLL, 2 SRL, 3 SRA)
//   shamt_i  in   5   shift amount 0..31
//   data_i   in  32   operand
//   busy_o   out  1   shifting in progress
//   stall_o  out  1   pipeline stall request (combinational)
//   done_o   out  1   one-cycle result-valid pulse
//   data_o   out 32   result register (intermediate values visible while busy)

module shift_seq_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    input  logic [4:0]  shamt_i,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] data_o
);

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] FUNCT_SLL  = 6'd0;
    localparam logic [5:0] FUNCT_SRL  = 6'd2;
    localparam logic [5:0] FUNCT_SRA  = 6'd3;

    // Only the low two funct bits are needed to tell the three shifts apart.
    localparam logic [1:0] SEL_SLL = 2'd0;
    localparam logic [1:0] SEL_SRL = 2'd2;
    localparam logic [1:0] SEL_SRA = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [1:0]  op_sel;
    logic [31:0] result;
    logic        valid_req;

    assign valid_req = start_i && (op_i == OP_SPECIAL) &&
                       ((funct_i == FUNCT_SLL) || (funct_i == FUNCT_SRL) ||
                        (funct_i == FUNCT_SRA));

    assign data_o = result;

    // Stall covers the accepting cycle too, so the pipeline holds the
    // instruction that is about to occupy the shifter. Zero-amount shifts
    // complete in one cycle and never stall. Forced low while in reset.
    assign stall_o = rst_i &&
                     ((state == SHIFT) ||
                      ((state != SHIFT) && valid_req && (shamt_i != 5'd0)));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            op_sel <= SEL_SLL;
            result <= 32'h0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else if (flush_i) begin
            // Result register deliberately left as-is.
            state  <= IDLE;
            cnt    <= 5'd0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (valid_req) begin
                        result <= data_i;
                        cnt    <= shamt_i;
                        op_sel <= funct_i[1:0];
                        if (shamt_i != 5'd0) begin
                            state  <= SHIFT;
                            busy_o <= 1'b1;
                            done_o <= 1'b0;
                        end else begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b0;
                    end
                end

                SHIFT: begin
                    case (op_sel)
                        SEL_SRL: result <= {1'b0, result[31:1]};
                        SEL_SRA: result <= {result[31], result[31:1]};
                        default: result <= {result[30:0], 1'b0};
                    endcase
                    cnt <= cnt - 5'd1;
                    // cnt is never 0 here: entry requires a nonzero amount
                    // and we leave on the 1 -> 0 step.
                    if (cnt == 5'd1) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= 5'd0;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - scoreboard testbench for shift_seq_ctrl

module tb_shift_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        flush_i;
    logic [5:0]  op_i;
    logic [5:0]  funct_i;
    logic [4:0]  shamt_i;
    logic [31:0] data_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] data_o;

    shift_seq_ctrl dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .flush_i (flush_i),
        .op_i    (op_i),
        .funct_i (funct_i),
        .shamt_i (shamt_i),
        .data_i  (data_i),
        .busy_o  (busy_o),
        .stall_o (stall_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          done_cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = 32'h0;
    bit          known    = 1'b0;

    function automatic bit is_valid(logic s, logic [5:0] op, logic [5:0] f);
        return s && (op == 6'd0) && (f == 6'd0 || f == 6'd2 || f == 6'd3);
    endfunction

    function automatic logic [31:0] ref_shift(logic [31:0] d, int n, logic [5:0] f);
        case (f)
            6'd2:    return d >> n;
            6'd3:    return unsigned'($signed(d) >>> n);
            default: return d << n;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: an operation accepted at edge e with amount N
    // completes (done visible) in the cycle following edge e+N.
    always @(posedge clk_i) begin
        cyc++;
        if (!rst_i) begin
            sb_q.delete();
            last_res = 32'h0;
            known    = 1'b1;
        end else if (flush_i) begin
            if (sb_q.size() != 0) begin
                sb_q.delete();
                known = 1'b0;
            end
        end else if (sb_q.size() == 0 && is_valid(start_i, op_i, funct_i)) begin
            sb_q.push_back('{cyc + int'(shamt_i), ref_shift(data_i, int'(shamt_i), funct_i)});
        end
    end

    // Monitor: compares DUT outputs every cycle away from the active edge.
    always @(negedge clk_i) begin
        bit exp_busy, exp_done, exp_stall;
        exp_busy  = (sb_q.size() != 0) && (sb_q[0].done_cyc > cyc);
        exp_done  = (sb_q.size() != 0) && (sb_q[0].done_cyc == cyc);
        exp_stall = rst_i && (exp_busy ||
                    (is_valid(start_i, op_i, funct_i) && shamt_i != 5'd0));
        if (cyc > 0) begin
            check("busy_o", {31'b0, busy_o}, {31'b0, exp_busy});
            check("done_o", {31'b0, done_o}, {31'b0, exp_done});
            check("stall_o", {31'b0, stall_o}, {31'b0, exp_stall});
            if (exp_done) begin
                check("result", data_o, sb_q[0].data);
                last_res = sb_q[0].data;
                known    = 1'b1;
                void'(sb_q.pop_front());
            end else if (!exp_busy && known) begin
                check("data_hold", data_o, last_res);
            end
        end
    end

    task automatic drive_idle();
        start_i = 1'b0;
        flush_i = 1'b0;
        op_i    = 6'd0;
        funct_i = 6'd0;
        shamt_i = 5'd0;
        data_i  = 32'h0;
    endtask

    // Present a request for one clock edge, then drop start.
    task automatic issue(logic [31:0] d, logic [4:0] n, logic [5:0] f);
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = 6'd0; funct_i = f; shamt_i = n; data_i = d;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(string name, logic [31:0] exp, int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                check(name, data_o, exp);
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no done_o within %0d cycles", name, bound);
        end
    endtask

    task automatic idle_cycles(int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        drive_idle();
        rst_i = 1'b0;
        start_i = 1'b1; shamt_i = 5'd7;   // reset must mask stall_o
        idle_cycles(3);
        check("reset_data", data_o, 32'h0);
        drive_idle();
        rst_i = 1'b1;
        idle_cycles(2);

        issue(32'h0000_0001, 5'd4, 6'd0);
        wait_done("sll4", 32'h0000_0010, 10);

        issue(32'h8000_0000, 5'd31, 6'd3);
        wait_done("sra31", 32'hFFFF_FFFF, 40);
        issue(32'h8000_0000, 5'd31, 6'd2);
        wait_done("srl31", 32'h0000_0001, 40);

        issue(32'h1234_5678, 5'd0, 6'd0);
        wait_done("zero_shift", 32'h1234_5678, 3);

        // Back-to-back: start held through SHIFT and DONE.
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = 6'd0; funct_i = 6'd0; shamt_i = 5'd3; data_i = 32'h0000_0003;
        @(posedge clk_i); #1;
        data_i = 32'h0000_0100; funct_i = 6'd2; shamt_i = 5'd2;
        wait_done("b2b_first", 32'h0000_0018, 8);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wait_done("b2b_second", 32'h0000_0040, 6);

        // Start pulsed during SHIFT is ignored.
        issue(32'h0000_00F0, 5'd5, 6'd0);
        idle_cycles(1);
        start_i = 1'b1; data_i = 32'hDEAD_BEEF; shamt_i = 5'd1;
        idle_cycles(1);
        start_i = 1'b0;
        wait_done("start_in_shift", 32'h0000_1E00, 8);

        // Flush in the 2nd SHIFT cycle of an 8-bit shift.
        issue(32'h0000_0001, 5'd8, 6'd0);
        idle_cycles(1);
        flush_i = 1'b1;
        idle_cycles(1);
        flush_i = 1'b0;
        check("flush_busy", {31'b0, busy_o}, 32'd0);
        idle_cycles(10);

        // Reset mid-shift.
        issue(32'hAAAA_5555, 5'd10, 6'd3);
        idle_cycles(3);
        rst_i = 1'b0;
        idle_cycles(1);
        rst_i = 1'b1;
        check("rst_mid_data", data_o, 32'h0);
        check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
        issue(32'h0000_0005, 5'd1, 6'd0);
        wait_done("after_reset", 32'h0000_000A, 4);

        // Invalid opcode with start.
        @(posedge clk_i); #1;
        start_i = 1'b1; op_i = 6'h23; funct_i = 6'd0; shamt_i = 5'd4; data_i = 32'h1111_1111;
        idle_cycles(3);
        drive_idle();
        check("invalid_hold", data_o, 32'h0000_000A);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk_i); #1;
            start_i = ($urandom_range(0, 1) == 1);
            op_i    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0;
            case ($urandom_range(0, 4))
                0: funct_i = 6'd0;
                1: funct_i = 6'd2;
                2: funct_i = 6'd3;
                3: funct_i = 6'd1;
                default: funct_i = 6'($urandom);
            endcase
            shamt_i = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            data_i  = $urandom;
            flush_i = ($urandom_range(0, 39) == 0);
            rst_i   = ($urandom_range(0, 99) != 0);
        end
        drive_idle();
        rst_i = 1'b1;
        idle_cycles(40);
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
